dma_dispatcher: RTL and testbench

- Descriptor scheduler for the PIM DMA engine.
- Accepts descriptors from the CSR block into a small FIFO and pops them one at a time.
- Hands each descriptor to the read-source FSM and the write-destination FSM with a one-cycle go, waits for both done pulses, then issues the next.
- Owns the dispatcher status: busy, error stop, FIFO state, completion count.

---
 rtl/dma_pkg.sv | 61 ++++++
 rtl/dma_desc_fifo.sv | 65 ++++++
 rtl/dma_dispatcher.sv | 137 +++++++++++++
 tb/tb_dma_dispatcher.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types for the PIM DMA engine: descriptor, CSR control/status, dispatcher states.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package dma_pkg;

  // Default number of queued descriptors held ahead of the dispatcher.
  localparam int DESC_FIFO_DEPTH = 8;

  // Status level field is sized for depths up to 128; narrower FIFO levels zero-extend.
  localparam int DESC_LEVEL_W = 8;

  typedef struct packed {
    logic [5:0] reserved;
    logic       irq_on_done;
    logic       go;
  } t_dma_desc_control;

  typedef struct packed {
    logic [31:0]       src_addr;
    logic [31:0]       dest_addr;
    logic [19:0]       length;
    t_dma_desc_control descriptor_control;
  } t_dma_descriptor;

  typedef struct packed {
    logic reset_dispatcher;
    logic stop_dispatcher;
  } t_dma_csr_control;

  typedef struct packed {
    logic                    busy;
    logic                    stopped_on_error;
    logic                    desc_fifo_empty;
    logic                    desc_fifo_full;
    logic [DESC_LEVEL_W-1:0] desc_fifo_level;
  } t_dma_csr_status;

  // Bit position of each dispatcher state inside the one-hot state vector.
  typedef enum logic [1:0] {
    IDLE_IDX      = 2'd0,
    ISSUE_IDX     = 2'd1,
    WAIT_DONE_IDX = 2'd2,
    ERROR_IDX     = 2'd3
  } t_disp_state_idx;

  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    ISSUE     = 4'b0010,
    WAIT_DONE = 4'b0100,
    ERROR     = 4'b1000
  } t_disp_state;

  // Returns the descriptor with its go bit forced to the given value.
  function automatic t_dma_descriptor with_go(input t_dma_descriptor d, input logic go);
    t_dma_descriptor r;
    r = d;
    r.descriptor_control.go = go;
    return r;
  endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// Show-ahead descriptor FIFO with synchronous flush and occupancy level.
// Latency: a push is visible at the head (empty=0) the cycle after it is written.
// Backpressure: pushes at full and pops at empty are ignored; flush beats both.
module dma_desc_fifo
  import dma_pkg::*;
#(
  parameter type T_DATA = t_dma_descriptor,
  parameter int  DEPTH  = DESC_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  T_DATA                  push_data,
  input  logic                   pop,
  output T_DATA                  pop_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  T_DATA            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             push_en;
  logic             pop_en;

  assign push_en  = push && !full && !flush;
  assign pop_en   = pop && !empty && !flush;
  assign empty    = (count == '0);
  assign full     = (count == LVL_W'(DEPTH));
  assign level    = count;
  assign pop_data = mem[rd_ptr];

  // Pointer and level bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dma_dispatcher.sv
// Descriptor scheduler: queues CSR descriptors and issues them one at a time to the read/write FSMs.
// Latency: push into an idle, empty dispatcher gives go two cycles later; back-to-back issues are 3 cycles apart.
// Backpressure: desc_in_ready drops when the queue is full or while reset_dispatcher is held.
module dma_dispatcher
  import dma_pkg::*;
#(
  parameter int DESC_DEPTH = DESC_FIFO_DEPTH,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             desc_in_valid,
  input  t_dma_descriptor  desc_in,
  output logic             desc_in_ready,
  input  t_dma_csr_control csr_control,
  output t_dma_descriptor  rd_desc,
  output t_dma_descriptor  wr_desc,
  input  logic             rd_fsm_done,
  input  logic             wr_fsm_done,
  input  logic             rd_error,
  input  logic             wr_error,
  output t_dma_csr_status  dispatcher_status,
  output logic [CNT_W-1:0] desc_done_count
);

  localparam int LVL_W = $clog2(DESC_DEPTH) + 1;

  t_disp_state     state;
  t_dma_descriptor work_desc;
  t_dma_descriptor fifo_head;
  logic            rd_seen;
  logic            wr_seen;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_empty;
  logic            fifo_full;
  logic [LVL_W-1:0] fifo_level;
  logic            both_done;
  logic            any_error;
  logic            in_idle;

  assign in_idle       = state[IDLE_IDX];
  assign desc_in_ready = !fifo_full && !csr_control.reset_dispatcher;
  assign fifo_push     = desc_in_valid && desc_in_ready;
  // Only an idle, unstopped dispatcher takes the next descriptor; ERROR leaves the queue untouched.
  assign fifo_pop      = in_idle && !fifo_empty && !csr_control.stop_dispatcher
                         && !csr_control.reset_dispatcher;
  // A done pulse counts in the cycle it arrives as well as once latched.
  assign both_done     = (rd_seen || rd_fsm_done) && (wr_seen || wr_fsm_done);
  assign any_error     = rd_error || wr_error;

  dma_desc_fifo #(
    .T_DATA (t_dma_descriptor),
    .DEPTH  (DESC_DEPTH)
  ) u_desc_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (csr_control.reset_dispatcher),
    .push      (fifo_push),
    .push_data (desc_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  // Dispatcher FSM with registered descriptor outputs, done tracking and completion counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      work_desc       <= '0;
      rd_desc         <= '0;
      wr_desc         <= '0;
      rd_seen         <= 1'b0;
      wr_seen         <= 1'b0;
      desc_done_count <= '0;
    end else if (csr_control.reset_dispatcher) begin
      // Abandon whatever is in flight; the completion count survives.
      state   <= IDLE;
      rd_desc <= with_go(rd_desc, 1'b0);
      wr_desc <= with_go(wr_desc, 1'b0);
      rd_seen <= 1'b0;
      wr_seen <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fifo_pop) begin
            work_desc <= fifo_head;
            rd_desc   <= with_go(fifo_head, 1'b1);
            wr_desc   <= with_go(fifo_head, 1'b1);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          // go was high for exactly this cycle; fields stay put while the FSMs work.
          rd_desc <= with_go(work_desc, 1'b0);
          wr_desc <= with_go(work_desc, 1'b0);
          rd_seen <= 1'b0;
          wr_seen <= 1'b0;
          state   <= any_error ? ERROR : WAIT_DONE;
        end
        WAIT_DONE: begin
          if (any_error) begin
            // Error beats a same-cycle completion: no count.
            state <= ERROR;
          end else if (both_done) begin
            desc_done_count <= desc_done_count + CNT_W'(1);
            state           <= IDLE;
          end else begin
            rd_seen <= rd_seen || rd_fsm_done;
            wr_seen <= wr_seen || wr_fsm_done;
          end
        end
        ERROR: begin
          // Sticky until reset_dispatcher; done pulses are ignored here.
          rd_desc <= with_go(rd_desc, 1'b0);
          wr_desc <= with_go(wr_desc, 1'b0);
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Status word seen by the CSR block.
  always_comb begin
    dispatcher_status                  = '0;
    dispatcher_status.busy             = !in_idle || (!fifo_empty && !csr_control.stop_dispatcher);
    dispatcher_status.stopped_on_error = state[ERROR_IDX];
    dispatcher_status.desc_fifo_empty  = fifo_empty;
    dispatcher_status.desc_fifo_full   = fifo_full;
    dispatcher_status.desc_fifo_level  = DESC_LEVEL_W'(fifo_level);
  end

endmodule

// File: tb/tb_dma_dispatcher.sv
// Directed bench for dma_dispatcher (DESC_DEPTH=8, CNT_W=4 so the counter wraps quickly).
// Inputs change on the falling edge; outputs are checked 1 time unit later, well away from the rising edge.
// A completion-count model in the bench tracks every finished descriptor.
module tb_dma_dispatcher;
  import dma_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             desc_in_valid;
  t_dma_descriptor  desc_in;
  logic             desc_in_ready;
  t_dma_csr_control csr_control;
  t_dma_descriptor  rd_desc;
  t_dma_descriptor  wr_desc;
  logic             rd_fsm_done;
  logic             wr_fsm_done;
  logic             rd_error;
  logic             wr_error;
  t_dma_csr_status  dispatcher_status;
  logic [CNT_W-1:0] desc_done_count;

  int               n_run  = 0;
  int               n_fail = 0;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  dma_dispatcher #(.DESC_DEPTH(8), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .desc_in_valid     (desc_in_valid),
    .desc_in           (desc_in),
    .desc_in_ready     (desc_in_ready),
    .csr_control       (csr_control),
    .rd_desc           (rd_desc),
    .wr_desc           (wr_desc),
    .rd_fsm_done       (rd_fsm_done),
    .wr_fsm_done       (wr_fsm_done),
    .rd_error          (rd_error),
    .wr_error          (wr_error),
    .dispatcher_status (dispatcher_status),
    .desc_done_count   (desc_done_count)
  );

  function automatic t_dma_descriptor mk(input logic [31:0] dst, input logic [19:0] len);
    t_dma_descriptor d;
    d = '0;
    d.src_addr  = dst ^ 32'h8000_0000;
    d.dest_addr = dst;
    d.length    = len;
    return d;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; desc_in_valid = 1'b0; desc_in = '0; csr_control = '0;
    rd_fsm_done = 1'b0; wr_fsm_done = 1'b0; rd_error = 1'b0; wr_error = 1'b0;
    exp_cnt = '0;
    repeat (2) tick();
    #1;
    n_run++; if (rd_desc !== '0) begin n_fail++; $display("FAIL reset_rd_desc: got %h want 0", rd_desc); end
    n_run++; if (wr_desc !== '0) begin n_fail++; $display("FAIL reset_wr_desc: got %h want 0", wr_desc); end
    n_run++; if (dispatcher_status !== t_dma_csr_status'({1'b0, 1'b0, 1'b1, 1'b0, 8'd0}))
      begin n_fail++; $display("FAIL reset_status: got %h want busy0 err0 empty1 full0 lvl0", dispatcher_status); end
    n_run++; if (desc_done_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", desc_done_count); end
    tick(); reset_n = 1'b1;
    #1;
    n_run++; if (desc_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", desc_in_ready); end
  endtask

  task automatic test_single();
    tick(); desc_in = mk(32'h1000, 20'd3); desc_in_valid = 1'b1; #1;
    n_run++; if (dispatcher_status.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_c0: got %b want 0", dispatcher_status.busy); end
    tick(); desc_in_valid = 1'b0; #1;
    n_run++; if (dispatcher_status.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_c1: got %b want 1", dispatcher_status.busy); end
    n_run++; if (dispatcher_status.desc_fifo_level !== 8'd1) begin n_fail++; $display("FAIL single_level_c1: got %0d want 1", dispatcher_status.desc_fifo_level); end
    n_run++; if (rd_desc.descriptor_control.go !== 1'b0) begin n_fail++; $display("FAIL single_go_c1: got %b want 0", rd_desc.descriptor_control.go); end
    tick(); #1;
    n_run++; if ({rd_desc.descriptor_control.go, wr_desc.descriptor_control.go} !== 2'b11)
      begin n_fail++; $display("FAIL single_go_c2: got %b%b want 11", rd_desc.descriptor_control.go, wr_desc.descriptor_control.go); end
    n_run++; if (rd_desc.dest_addr !== 32'h1000) begin n_fail++; $display("FAIL single_rd_addr: got %h want 1000", rd_desc.dest_addr); end
    n_run++; if (wr_desc.length !== 20'd3) begin n_fail++; $display("FAIL single_wr_len: got %0d want 3", wr_desc.length); end
    tick(); #1;
    n_run++; if ({rd_desc.descriptor_control.go, wr_desc.descriptor_control.go} !== 2'b00)
      begin n_fail++; $display("FAIL single_go_c3: got %b%b want 00", rd_desc.descriptor_control.go, wr_desc.descriptor_control.go); end
    n_run++; if (wr_desc.dest_addr !== 32'h1000) begin n_fail++; $display("FAIL single_hold_addr: got %h want 1000", wr_desc.dest_addr); end
    repeat (6) tick();
    tick(); rd_fsm_done = 1'b1;
    tick(); rd_fsm_done = 1'b0;
    repeat (3) tick();
    tick(); wr_fsm_done = 1'b1; #1;
    n_run++; if (desc_done_count !== exp_cnt) begin n_fail++; $display("FAIL single_cnt_before: got %0d want %0d", desc_done_count, exp_cnt); end
    n_run++; if (dispatcher_status.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_c15: got %b want 1", dispatcher_status.busy); end
    tick(); wr_fsm_done = 1'b0; exp_cnt++; #1;
    n_run++; if (desc_done_count !== exp_cnt) begin n_fail++; $display("FAIL single_cnt_after: got %0d want %0d", desc_done_count, exp_cnt); end
    tick(); #1;
    n_run++; if (dispatcher_status.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got busy %b want 0", dispatcher_status.busy); end
  endtask

  task automatic test_done_order();
    // Write side finishes first, read side 5 cycles later.
    tick(); desc_in = mk(32'h1100, 20'd4); desc_in_valid = 1'b1;
    tick(); desc_in_valid = 1'b0;
    tick(); #1;
    n_run++; if (rd_desc.descriptor_control.go !== 1'b1) begin n_fail++; $display("FAIL order_go: got %b want 1", rd_desc.descriptor_control.go); end
    tick(); wr_fsm_done = 1'b1;
    tick(); wr_fsm_done = 1'b0;
    repeat (3) tick();
    tick(); rd_fsm_done = 1'b1; #1;
    n_run++; if (desc_done_count !== exp_cnt) begin n_fail++; $display("FAIL order_cnt_early: got %0d want %0d", desc_done_count, exp_cnt); end
    tick(); rd_fsm_done = 1'b0; exp_cnt++; #1;
    n_run++; if (desc_done_count !== exp_cnt) begin n_fail++; $display("FAIL order_cnt: got %0d want %0d", desc_done_count, exp_cnt); end
    // Both sides finish in the same cycle.
    tick(); desc_in = mk(32'h1200, 20'd5); desc_in_valid = 1'b1;
    tick(); desc_in_valid = 1'b0;
    tick();
    tick(); rd_fsm_done = 1'b1; wr_fsm_done = 1'b1;
    tick(); rd_fsm_done = 1'b0; wr_fsm_done = 1'b0; exp_cnt++; #1;
    n_run++; if (desc_done_count !== exp_cnt) begin n_fail++; $display("FAIL same_cnt: got %0d want %0d", desc_done_count, exp_cnt); end
    n_run++; if (dispatcher_status.busy !== 1'b0) begin n_fail++; $display("FAIL same_busy: got %b want 0", dispatcher_status.busy); end
  endtask

  task automatic test_back_to_back();
    int n_go;
    int last;
    logic pend;
    csr_control.stop_dispatcher = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(); desc_in = mk(32'h2000 + 32'(i * 16), 20'(i + 1)); desc_in_valid = 1'b1; #1;
      n_run++; if (desc_in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_%0d: got %b want 1", i, desc_in_ready); end
    end
    tick(); desc_in = mk(32'h9999, 20'd9); #1;
    n_run++; if (dispatcher_status.desc_fifo_full !== 1'b1) begin n_fail++; $display("FAIL b2b_full: got %b want 1", dispatcher_status.desc_fifo_full); end
    n_run++; if (desc_in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full: got %b want 0", desc_in_ready); end
    n_run++; if (dispatcher_status.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_stopped: got %b want 0", dispatcher_status.busy); end
    tick(); desc_in_valid = 1'b0; #1;
    n_run++; if (dispatcher_status.desc_fifo_level !== 8'd8) begin n_fail++; $display("FAIL b2b_level: got %0d want 8", dispatcher_status.desc_fifo_level); end
    tick(); csr_control.stop_dispatcher = 1'b0;
    n_go = 0; last = 0; pend = 1'b0;
    for (int c = 0; c < 60 && n_go < 8; c++) begin
      tick(); rd_fsm_done = pend; wr_fsm_done = pend; #1;
      pend = 1'b0;
      if (rd_desc.descriptor_control.go === 1'b1) begin
        n_run++; if (wr_desc.descriptor_control.go !== 1'b1) begin n_fail++; $display("FAIL b2b_wr_go_%0d: got %b want 1", n_go, wr_desc.descriptor_control.go); end
        n_run++; if (rd_desc.dest_addr !== 32'h2000 + 32'(n_go * 16))
          begin n_fail++; $display("FAIL b2b_order_%0d: got %h want %h", n_go, rd_desc.dest_addr, 32'h2000 + 32'(n_go * 16)); end
        if (n_go > 0) begin
          n_run++; if (c - last != 3) begin n_fail++; $display("FAIL b2b_gap_%0d: got %0d want 3", n_go, c - last); end
        end
        last = c; n_go++; pend = 1'b1;
      end
    end
    tick(); rd_fsm_done = pend; wr_fsm_done = pend;
    tick(); rd_fsm_done = 1'b0; wr_fsm_done = 1'b0; #1;
    exp_cnt = exp_cnt + 4'd8;
    n_run++; if (n_go != 8) begin n_fail++; $display("FAIL b2b_go_count: got %0d want 8", n_go); end
    n_run++; if (desc_done_count !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt: got %0d want %0d", desc_done_count, exp_cnt); end
    n_run++; if (dispatcher_status.desc_fifo_empty !== 1'b1) begin n_fail++; $display("FAIL b2b_empty: got %b want 1", dispatcher_status.desc_fifo_empty); end
  endtask

  task automatic test_error();
    csr_control.stop_dispatcher = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); desc_in = mk(32'h3000 + 32'(i * 16), 20'd7); desc_in_valid = 1'b1;
    end
    tick(); desc_in_valid = 1'b0; csr_control.stop_dispatcher = 1'b0;
    tick(); #1;
    n_run++; if (rd_desc.descriptor_control.go !== 1'b1) begin n_fail++; $display("FAIL err_go: got %b want 1", rd_desc.descriptor_control.go); end
    tick(); rd_fsm_done = 1'b1;
    tick(); rd_fsm_done = 1'b0;
    // Completion and error arrive together: error wins.
    tick(); wr_fsm_done = 1'b1; wr_error = 1'b1;
    tick(); wr_fsm_done = 1'b0; wr_error = 1'b0; #1;
    n_run++; if (dispatcher_status.stopped_on_error !== 1'b1) begin n_fail++; $display("FAIL err_stopped: got %b want 1", dispatcher_status.stopped_on_error); end
    n_run++; if (desc_done_count !== exp_cnt) begin n_fail++; $display("FAIL err_cnt: got %0d want %0d", desc_done_count, exp_cnt); end
    n_run++; if (dispatcher_status.desc_fifo_level !== 8'd2) begin n_fail++; $display("FAIL err_level: got %0d want 2", dispatcher_status.desc_fifo_level); end
    n_run++; if (dispatcher_status.busy !== 1'b1) begin n_fail++; $display("FAIL err_busy: got %b want 1", dispatcher_status.busy); end
    tick(); rd_fsm_done = 1'b1; wr_fsm_done = 1'b1; desc_in = mk(32'h3030, 20'd7); desc_in_valid = 1'b1; #1;
    n_run++; if (desc_in_ready !== 1'b1) begin n_fail++; $display("FAIL err_ready: got %b want 1", desc_in_ready); end
    tick(); rd_fsm_done = 1'b0; wr_fsm_done = 1'b0; desc_in_valid = 1'b0; #1;
    n_run++; if (dispatcher_status.desc_fifo_level !== 8'd3) begin n_fail++; $display("FAIL err_push_level: got %0d want 3", dispatcher_status.desc_fifo_level); end
    n_run++; if (desc_done_count !== exp_cnt) begin n_fail++; $display("FAIL err_done_ignored: got %0d want %0d", desc_done_count, exp_cnt); end
    repeat (3) tick();
    #1;
    n_run++; if (rd_desc.descriptor_control.go !== 1'b0) begin n_fail++; $display("FAIL err_no_go: got %b want 0", rd_desc.descriptor_control.go); end
    tick(); csr_control.reset_dispatcher = 1'b1; desc_in_valid = 1'b1; #1;
    n_run++; if (desc_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_disp_ready: got %b want 0", desc_in_ready); end
    tick(); csr_control.reset_dispatcher = 1'b0; desc_in_valid = 1'b0; #1;
    n_run++; if (dispatcher_status !== t_dma_csr_status'({1'b0, 1'b0, 1'b1, 1'b0, 8'd0}))
      begin n_fail++; $display("FAIL rst_disp_status: got %h want busy0 err0 empty1 full0 lvl0", dispatcher_status); end
    n_run++; if (desc_done_count !== exp_cnt) begin n_fail++; $display("FAIL rst_disp_cnt: got %0d want %0d", desc_done_count, exp_cnt); end
    tick(); rd_fsm_done = 1'b1; wr_fsm_done = 1'b1;
    tick(); rd_fsm_done = 1'b0; wr_fsm_done = 1'b0; #1;
    n_run++; if (desc_done_count !== exp_cnt) begin n_fail++; $display("FAIL stray_done_cnt: got %0d want %0d", desc_done_count, exp_cnt); end
  endtask

  task automatic test_stop_inflight();
    tick(); desc_in = mk(32'h4000, 20'd1); desc_in_valid = 1'b1;
    tick(); desc_in = mk(32'h4010, 20'd2);
    tick(); desc_in_valid = 1'b0; #1;
    n_run++; if (rd_desc.dest_addr !== 32'h4000) begin n_fail++; $display("FAIL stop_first_addr: got %h want 4000", rd_desc.dest_addr); end
    tick(); csr_control.stop_dispatcher = 1'b1;
    tick(); rd_fsm_done = 1'b1; wr_fsm_done = 1'b1;
    tick(); rd_fsm_done = 1'b0; wr_fsm_done = 1'b0; exp_cnt++; #1;
    n_run++; if (desc_done_count !== exp_cnt) begin n_fail++; $display("FAIL stop_inflight_cnt: got %0d want %0d", desc_done_count, exp_cnt); end
    n_run++; if (dispatcher_status.desc_fifo_level !== 8'd1) begin n_fail++; $display("FAIL stop_level: got %0d want 1", dispatcher_status.desc_fifo_level); end
    repeat (2) tick();
    #1;
    n_run++; if (rd_desc.descriptor_control.go !== 1'b0) begin n_fail++; $display("FAIL stop_held: got go %b want 0", rd_desc.descriptor_control.go); end
    tick(); csr_control.stop_dispatcher = 1'b0;
    tick(); #1;
    n_run++; if ({rd_desc.descriptor_control.go, rd_desc.dest_addr} !== {1'b1, 32'h4010})
      begin n_fail++; $display("FAIL stop_release: got go %b addr %h want go 1 addr 4010", rd_desc.descriptor_control.go, rd_desc.dest_addr); end
    tick(); rd_fsm_done = 1'b1; wr_fsm_done = 1'b1;
    tick(); rd_fsm_done = 1'b0; wr_fsm_done = 1'b0; exp_cnt++;
  endtask

  task automatic test_async_reset();
    tick(); desc_in = mk(32'h5000, 20'd8); desc_in_valid = 1'b1;
    tick(); desc_in_valid = 1'b0;
    tick();
    tick(); #3;
    reset_n = 1'b0; exp_cnt = '0;
    #1;
    n_run++; if (rd_desc !== '0 || wr_desc !== '0) begin n_fail++; $display("FAIL async_desc: got rd %h wr %h want 0", rd_desc, wr_desc); end
    n_run++; if (dispatcher_status !== t_dma_csr_status'({1'b0, 1'b0, 1'b1, 1'b0, 8'd0}))
      begin n_fail++; $display("FAIL async_status: got %h want busy0 err0 empty1 full0 lvl0", dispatcher_status); end
    n_run++; if (desc_done_count !== exp_cnt) begin n_fail++; $display("FAIL async_cnt: got %0d want 0", desc_done_count); end
    tick(); reset_n = 1'b1;
  endtask

  task automatic test_counter_wrap();
    logic got;
    for (int i = 0; i < 17; i++) begin
      tick(); desc_in = mk(32'h6000 + 32'(i * 16), 20'd1); desc_in_valid = 1'b1;
      tick(); desc_in_valid = 1'b0;
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
        tick(); #1;
        if (rd_desc.descriptor_control.go === 1'b1) got = 1'b1;
      end
      n_run++; if (got !== 1'b1) begin n_fail++; $display("FAIL wrap_go_timeout_%0d: got no go want go", i); end
      tick(); rd_fsm_done = 1'b1; wr_fsm_done = 1'b1;
      tick(); rd_fsm_done = 1'b0; wr_fsm_done = 1'b0; exp_cnt++;
    end
    #1;
    n_run++; if (desc_done_count !== exp_cnt) begin n_fail++; $display("FAIL wrap_cnt_model: got %0d want %0d", desc_done_count, exp_cnt); end
    n_run++; if (desc_done_count !== 4'd1) begin n_fail++; $display("FAIL wrap_cnt: got %0d want 1", desc_done_count); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_done_order();
    test_back_to_back();
    test_error();
    test_stop_inflight();
    test_async_reset();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
